// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, CON/STAT bit positions and FSM state encodings for the UART
package uart_pkg;

  localparam logic [31:0] OFF_TXDATA = 32'h0;
  localparam logic [31:0] OFF_RXDATA = 32'h4;
  localparam logic [31:0] OFF_CON    = 32'h8;
  localparam logic [31:0] OFF_STAT   = 32'hC;

  localparam int CON_TX_EN   = 0;
  localparam int CON_RX_EN   = 1;
  localparam int CON_PAR_EN  = 2;
  localparam int CON_PAR_ODD = 3;
  localparam int CON_RX_IE   = 4;
  localparam int CON_TX_IE   = 5;
  localparam int CON_W       = 6;

  localparam int STAT_TX_FULL   = 0;
  localparam int STAT_TX_EMPTY  = 1;
  localparam int STAT_RX_FULL   = 2;
  localparam int STAT_RX_EMPTY  = 3;
  localparam int STAT_RX_OVR    = 4;
  localparam int STAT_FRAME_ERR = 5;
  localparam int STAT_PAR_ERR   = 6;
  localparam int STAT_TX_BUSY   = 7;
  localparam int STAT_TX_OVF    = 8;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_fifo_peripheral_if.sv
// rtl/uart_fifo_peripheral_if.sv - single-cycle CPU bus as seen by the UART
interface uart_fifo_peripheral_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO; a pop frees room for a push in the same cycle
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/uart_fifo_peripheral.sv
// rtl/uart_fifo_peripheral.sv - FIFO-buffered UART with parity, sticky error flags and interrupt
module uart_fifo_peripheral
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0018,
  parameter int          BAUD_DIV   = 651,
  parameter int          DATA_BITS  = 8,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_fifo_peripheral_if.slave bus,
  input  logic                  uart_rx,
  output logic                  uart_tx,
  output logic                  irq
);
  localparam int CNT_W = $clog2(BAUD_DIV + 1);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  logic sel_tx, sel_rx, sel_con, sel_stat;
  assign sel_tx   = (bus.addr == BASE_ADDR + OFF_TXDATA);
  assign sel_rx   = (bus.addr == BASE_ADDR + OFF_RXDATA);
  assign sel_con  = (bus.addr == BASE_ADDR + OFF_CON);
  assign sel_stat = (bus.addr == BASE_ADDR + OFF_STAT);

  logic [CNT_W-1:0] baud_q;
  logic             tick;
  assign tick = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    baud_q <= '0;
    else if (tick) baud_q <= '0;
    else           baud_q <= baud_q + 1'b1;
  end

  logic [CON_W-1:0] con_q;
  logic tx_en, rx_en, par_en, par_odd, rx_ie, tx_ie;
  assign tx_en   = con_q[CON_TX_EN];
  assign rx_en   = con_q[CON_RX_EN];
  assign par_en  = con_q[CON_PAR_EN];
  assign par_odd = con_q[CON_PAR_ODD];
  assign rx_ie   = con_q[CON_RX_IE];
  assign tx_ie   = con_q[CON_TX_IE];

  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_BITS-1:0] tx_head;
  logic [CW-1:0]        tx_count;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_BITS-1:0] rx_head;
  logic [CW-1:0]        rx_count;

  assign tx_push = bus.wr & sel_tx;
  assign rx_pop  = bus.rd & sel_rx & ~rx_empty;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .wdata(bus.wdata[DATA_BITS-1:0]),
    .pop(tx_pop), .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .wdata(rx_shift_q),
    .pop(rx_pop), .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // TX: frames start on a baud tick so every bit, including the start bit, is exactly 16 ticks
  tx_state_e            tx_state_q, tx_state_d;
  logic [3:0]           tx_tick_q, tx_tick_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_bit_end, tx_load, tx_busy;

  assign tx_bit_end = tick & (tx_tick_q == 4'd15);
  assign tx_load    = tick & tx_en & ~tx_empty &
                      ((tx_state_q == TX_IDLE) | ((tx_state_q == TX_STOP) & (tx_tick_q == 4'd15)));
  assign tx_pop     = tx_load;
  assign tx_busy    = (tx_state_q != TX_IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    if (tx_busy && tick) tx_tick_d = tx_tick_q + 4'd1;
    case (tx_state_q)
      TX_START:  if (tx_bit_end) begin
                   tx_state_d = TX_DATA;
                   tx_bit_d   = 3'd0;
                 end
      TX_DATA:   if (tx_bit_end) begin
                   tx_shift_d = tx_shift_q >> 1;
                   if (tx_bit_q == LAST_BIT) tx_state_d = par_en ? TX_PARITY : TX_STOP;
                   else                      tx_bit_d   = tx_bit_q + 3'd1;
                 end
      TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP;
      TX_STOP:   if (tx_bit_end) tx_state_d = TX_IDLE;
      default:   tx_state_d = TX_IDLE;
    endcase
    if (tx_load) begin
      tx_state_d = TX_START;
      tx_tick_d  = 4'd0;
      tx_shift_d = tx_head;
      tx_par_d   = (^tx_head) ^ par_odd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
    end
  end

  always_comb begin
    case (tx_state_q)
      TX_START:  uart_tx = 1'b0;
      TX_DATA:   uart_tx = tx_shift_q[0];
      TX_PARITY: uart_tx = tx_par_q;
      default:   uart_tx = 1'b1;
    endcase
  end

  // RX: tick 7 of the 0-based per-bit counter is the mid-bit sample point
  logic       rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e  rx_state_q, rx_state_d;
  logic [3:0] rx_tick_q, rx_tick_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic       rx_bad_q, rx_bad_d;
  logic       rx_sample, rx_bit_end, par_set, frame_set;

  assign rx_sample  = tick & (rx_tick_q == 4'd7);
  assign rx_bit_end = tick & (rx_tick_q == 4'd15);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_bad_d   = rx_bad_q;
    rx_push    = 1'b0;
    par_set    = 1'b0;
    frame_set  = 1'b0;
    if (rx_state_q != RX_IDLE && tick) rx_tick_d = rx_tick_q + 4'd1;
    if (!rx_en) begin
      rx_state_d = RX_IDLE;
    end else begin
      case (rx_state_q)
        RX_IDLE:   if (rx_prev_q && !rx_s2_q) begin
                     rx_state_d = RX_START;
                     rx_tick_d  = 4'd0;
                     rx_bad_d   = 1'b0;
                   end
        RX_START:  if (rx_sample && rx_s2_q) rx_state_d = RX_IDLE;
                   else if (rx_bit_end) begin
                     rx_state_d = RX_DATA;
                     rx_bit_d   = 3'd0;
                   end
        RX_DATA: begin
                   if (rx_sample) rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                   if (rx_bit_end) begin
                     if (rx_bit_q == LAST_BIT) rx_state_d = par_en ? RX_PARITY : RX_STOP;
                     else                      rx_bit_d   = rx_bit_q + 3'd1;
                   end
                 end
        RX_PARITY: begin
                     if (rx_sample && (rx_s2_q != ((^rx_shift_q) ^ par_odd))) begin
                       par_set  = 1'b1;
                       rx_bad_d = 1'b1;
                     end
                     if (rx_bit_end) rx_state_d = RX_STOP;
                   end
        RX_STOP:   if (rx_sample) begin
                     rx_state_d = RX_IDLE;
                     if (!rx_s2_q)      frame_set = 1'b1;
                     else if (!rx_bad_q) rx_push  = 1'b1;
                   end
        default:   rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_bad_q   <= 1'b0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_bad_q   <= rx_bad_d;
    end
  end

  // sticky flags: a set in the same cycle as a write-1 clear wins
  logic rx_ovr_q, frame_err_q, par_err_q, tx_ovf_q;
  logic stat_wr;
  assign stat_wr = bus.wr & sel_stat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      con_q       <= '0;
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      tx_ovf_q    <= 1'b0;
    end else begin
      if (bus.wr && sel_con) con_q <= bus.wdata[CON_W-1:0];
      rx_ovr_q    <= (rx_ovr_q    & ~(stat_wr & bus.wdata[STAT_RX_OVR]))    | (rx_push & rx_full & ~rx_pop);
      frame_err_q <= (frame_err_q & ~(stat_wr & bus.wdata[STAT_FRAME_ERR])) | frame_set;
      par_err_q   <= (par_err_q   & ~(stat_wr & bus.wdata[STAT_PAR_ERR]))   | par_set;
      tx_ovf_q    <= (tx_ovf_q    & ~(stat_wr & bus.wdata[STAT_TX_OVF]))    | (tx_push & tx_full & ~tx_pop);
    end
  end

  logic [31:0] stat, rdata_c;
  always_comb begin
    stat                 = '0;
    stat[STAT_TX_FULL]   = tx_full;
    stat[STAT_TX_EMPTY]  = tx_empty;
    stat[STAT_RX_FULL]   = rx_full;
    stat[STAT_RX_EMPTY]  = rx_empty;
    stat[STAT_RX_OVR]    = rx_ovr_q;
    stat[STAT_FRAME_ERR] = frame_err_q;
    stat[STAT_PAR_ERR]   = par_err_q;
    stat[STAT_TX_BUSY]   = tx_busy;
    stat[STAT_TX_OVF]    = tx_ovf_q;
    stat[23:16]          = 8'(rx_count);
  end

  always_comb begin
    rdata_c = '0;
    if (bus.rd) begin
      if (sel_rx && !rx_empty) rdata_c[DATA_BITS-1:0] = rx_head;
      else if (sel_con)        rdata_c[CON_W-1:0]     = con_q;
      else if (sel_stat)       rdata_c                = stat;
    end
  end

  assign bus.rdata = rdata_c;
  assign irq = (rx_ie & ~rx_empty) | (tx_ie & tx_empty & ~tx_busy);

  logic unused_bits;
  assign unused_bits = ^{tx_count, bus.wdata[31:9]};
endmodule
